// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operand request handshake in, result handshake out.
// The master drives requests and consumes results; the slave is the ALU.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ans;
    logic [2:0]       flags;

    modport master (
        output in_valid, op, num1, num2, out_ready,
        input  in_ready, out_valid, ans, flags
    );

    modport slave (
        input  in_valid, op, num1, num2, out_ready,
        output in_ready, out_valid, ans, flags
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/shift ops, bit-serial multiply and restoring divide.
// One request in flight; result and {dz, ovf, zero} held until the consumer takes them.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    localparam int unsigned CW = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b1101;
    localparam logic [3:0] OP_SRL  = 4'b1110;
    localparam logic [3:0] OP_SRA  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mop_q, mop_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic [2:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] mc_res;
    logic             mc_dz;

    // Single-cycle datapath, evaluated on the live request and captured at accept.
    always_comb begin
        sh       = bus.num2[SHW-1:0];
        add_sum  = bus.num1 + bus.num2;
        sub_diff = bus.num1 - bus.num2;
        alu_res  = '0;
        alu_ovf  = 1'b0;
        case (bus.op)
            OP_AND:  alu_res = bus.num1 & bus.num2;
            OP_OR:   alu_res = bus.num1 | bus.num2;
            OP_ADD: begin
                alu_res = add_sum;
                alu_ovf = (bus.num1[WIDTH-1] == bus.num2[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != bus.num1[WIDTH-1]);
            end
            OP_NOT:  alu_res = ~bus.num1;
            OP_SUB: begin
                alu_res = sub_diff;
                alu_ovf = (bus.num1[WIDTH-1] != bus.num2[WIDTH-1]) &&
                          (sub_diff[WIDTH-1] != bus.num1[WIDTH-1]);
            end
            OP_SLTU: alu_res = WIDTH'(bus.num1 < bus.num2);
            OP_XOR:  alu_res = bus.num1 ^ bus.num2;
            OP_SLL:  alu_res = bus.num1 << sh;
            OP_SRL:  alu_res = bus.num1 >> sh;
            OP_SRA:  alu_res = WIDTH'($signed(bus.num1) >>> sh);
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide; hi/lo hold product or remainder/quotient.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
        div_trial = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, b_q};
        div_diff  = div_trial - {1'b0, b_q};
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mop_d       = mop_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        ans_d       = ans_q;
        flags_d     = flags_q;
        mc_res      = '0;
        mc_dz       = 1'b0;
        accept      = bus.in_valid && in_ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mop_d = bus.op[1:0];
                    b_d   = bus.num2;
                    cnt_d = '0;
                    if (bus.op[3:2] == 2'b10) begin
                        state_d = BUSY;
                        hi_d    = '0;
                        lo_d    = bus.num1;
                    end else begin
                        state_d = DONE;
                        ans_d   = alu_res;
                        flags_d = {1'b0, alu_ovf, alu_res == '0};
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (!mop_q[1]) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end
                // A zero divisor naturally yields quotient all-ones and remainder num1.
                mc_res = mop_q[0] ? hi_d : lo_d;
                mc_dz  = mop_q[1] && (b_q == '0);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    ans_d   = mc_res;
                    flags_d = {mc_dz, 1'b0, mc_res == '0};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mop_q       <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            ans_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mop_q       <= mop_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            ans_q       <= ans_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ans       = ans_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed scenarios on a 32-bit instance, then random traffic on
// 8-bit and 32-bit instances scored against an arithmetic reference model.
module tb_seq_alu;
    typedef struct packed {
        logic [63:0] ans;
        logic [2:0]  flags;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   rand_on = 1'b0;

    res_t q32[$];
    res_t q8[$];
    res_t e32, e8;
    int   acc32 = 0, done32 = 0, acc8 = 0, done8 = 0;

    seq_alu_if #(.WIDTH(32)) b32 ();
    seq_alu_if #(.WIDTH(8))  b8 ();

    seq_alu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference results straight from the operation definitions, for widths up to 32.
    function automatic res_t ref_model(input int w, input logic [3:0] o,
                                       input logic [63:0] a_in, input logic [63:0] b_in);
        res_t        r;
        logic [63:0] m, a, b, sa, prod;
        int          sh;
        logic        ovf, dz;
        m    = (64'd1 << w) - 64'd1;
        a    = a_in & m;
        b    = b_in & m;
        sh   = int'(b % 64'(w));
        prod = a * b;
        ovf  = 1'b0;
        dz   = 1'b0;
        r.ans = 64'd0;
        case (o)
            4'd0:  r.ans = a & b;
            4'd1:  r.ans = a | b;
            4'd2: begin
                r.ans = (a + b) & m;
                ovf   = (a[w-1] == b[w-1]) && (r.ans[w-1] != a[w-1]);
            end
            4'd4:  r.ans = ~a & m;
            4'd6: begin
                r.ans = (a - b) & m;
                ovf   = (a[w-1] != b[w-1]) && (r.ans[w-1] != a[w-1]);
            end
            4'd7:  r.ans = (a < b) ? 64'd1 : 64'd0;
            4'd8:  r.ans = prod & m;
            4'd9:  r.ans = (prod >> w) & m;
            4'd10: begin dz = (b == 0); r.ans = dz ? m : a / b; end
            4'd11: begin dz = (b == 0); r.ans = dz ? a : a % b; end
            4'd12: r.ans = a ^ b;
            4'd13: r.ans = (a << sh) & m;
            4'd14: r.ans = a >> sh;
            4'd15: begin
                sa    = a[w-1] ? (a | ~m) : a;
                r.ans = 64'($signed(sa) >>> sh) & m;
            end
            default: r.ans = 64'd0;
        endcase
        r.flags = {dz, ovf, r.ans == 64'd0};
        return r;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [63:0] m, v;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'd1;
            2: v = m;
            3: v = 64'd1 << (w - 1);
            4: v = (64'd1 << (w - 1)) - 64'd1;
            5: v = 64'($urandom_range(0, 40));
            default: v = 64'($urandom);
        endcase
        return 32'(v & m);
    endfunction

    // One directed transaction: inputs are scrambled and in_valid held high while busy.
    task automatic xfer(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] bb, input logic [31:0] ea, input logic [2:0] ef,
                        input int elat, input int hold);
        int guard, lat;
        bit rdy_seen;
        guard = 0;
        while (!b32.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready"}, 64'(b32.in_ready), 64'd1);
        b32.op = o; b32.num1 = a; b32.num2 = bb; b32.in_valid = 1'b1; b32.out_ready = 1'b0;
        @(posedge clk); #1;
        b32.op = ~o; b32.num1 = ~a; b32.num2 = ~bb;
        lat = 1;
        rdy_seen = b32.in_ready;
        while (!b32.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            rdy_seen |= b32.in_ready;
        end
        b32.in_valid = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_ans"}, 64'(b32.ans), 64'(ea));
        check({tag, "_flags"}, 64'(b32.flags), 64'(ef));
        check({tag, "_busy_ready"}, 64'(rdy_seen), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(b32.out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(b32.in_ready), 64'd0);
            check({tag, "_hold_ans"}, 64'(b32.ans), 64'(ea));
            check({tag, "_hold_flags"}, 64'(b32.flags), 64'(ef));
        end
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        check({tag, "_release_valid"}, 64'(b32.out_valid), 64'd0);
        check({tag, "_release_ready"}, 64'(b32.in_ready), 64'd1);
        check({tag, "_retain_ans"}, 64'(b32.ans), 64'(ea));
    endtask

    // Scoreboards: requests seen at accept, results compared at delivery.
    always @(negedge clk) begin
        if (rand_on) begin
            if (b32.in_valid && b32.in_ready) begin
                q32.push_back(ref_model(32, b32.op, 64'(b32.num1), 64'(b32.num2)));
                acc32++;
            end
            if (b32.out_valid && b32.out_ready) begin
                check("w32_expected_pending", 64'(q32.size() > 0), 64'd1);
                if (q32.size() > 0) begin
                    e32 = q32.pop_front();
                    check("w32_ans", 64'(b32.ans), e32.ans);
                    check("w32_flags", 64'(b32.flags), 64'(e32.flags));
                    done32++;
                end
            end
            if (b8.in_valid && b8.in_ready) begin
                q8.push_back(ref_model(8, b8.op, 64'(b8.num1), 64'(b8.num2)));
                acc8++;
            end
            if (b8.out_valid && b8.out_ready) begin
                check("w8_expected_pending", 64'(q8.size() > 0), 64'd1);
                if (q8.size() > 0) begin
                    e8 = q8.pop_front();
                    check("w8_ans", 64'(b8.ans), e8.ans);
                    check("w8_flags", 64'(b8.flags), 64'(e8.flags));
                    done8++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.op = '0; b32.num1 = '0; b32.num2 = '0;
        b8.in_valid  = 1'b0; b8.out_ready  = 1'b0; b8.op  = '0; b8.num1  = '0; b8.num2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(b32.in_ready), 64'd0);
        check("reset_out_valid", 64'(b32.out_valid), 64'd0);
        check("reset_ans", 64'(b32.ans), 64'd0);
        check("reset_flags", 64'(b32.flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_ready", 64'(b32.in_ready), 64'd1);

        xfer("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b010, 1, 0);
        xfer("mul",     4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 33, 0);
        xfer("mulhu",   4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b000, 33, 0);
        xfer("sub_hold", 4'b0110, 32'd5, 32'd5, 32'd0, 3'b001, 1, 10);
        xfer("divu",    4'b1010, 32'd100, 32'd7, 32'd14, 3'b000, 33, 0);
        xfer("remu",    4'b1011, 32'd100, 32'd7, 32'd2, 3'b000, 33, 0);
        xfer("divu_dz", 4'b1010, 32'd5, 32'd0, 32'hFFFF_FFFF, 3'b100, 33, 0);
        xfer("remu_dz", 4'b1011, 32'd5, 32'd0, 32'd5, 3'b100, 33, 0);
        xfer("rsvd3",   4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 3'b001, 1, 0);
        xfer("sltu",    4'b0111, 32'd3, 32'hFFFF_FFF0, 32'd1, 3'b000, 1, 0);

        // Abort a divide ten cycles into its run.
        b32.op = 4'b1010; b32.num1 = 32'd100; b32.num2 = 32'd7; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(b32.out_valid), 64'd0);
        check("abort_ans", 64'(b32.ans), 64'd0);
        check("abort_flags", 64'(b32.flags), 64'd0);
        check("abort_ready", 64'(b32.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_recover_ready", 64'(b32.in_ready), 64'd1);
        xfer("sra", 4'b1111, 32'h8000_0000, 32'd4, 32'hF800_0000, 3'b000, 1, 0);

        rand_on = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            b32.in_valid  = ($urandom_range(0, 9) < 6);
            b32.op        = 4'($urandom);
            b32.num1      = pick(32);
            b32.num2      = pick(32);
            b32.out_ready = 1'($urandom_range(0, 1));
            b8.in_valid   = ($urandom_range(0, 9) < 6);
            b8.op         = 4'($urandom);
            b8.num1       = 8'(pick(8));
            b8.num2       = 8'(pick(8));
            b8.out_ready  = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.out_ready  = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        rand_on = 1'b0;
        check("w32_drained", 64'(q32.size()), 64'd0);
        check("w8_drained", 64'(q8.size()), 64'd0);
        check("w32_accept_vs_deliver", 64'(done32), 64'(acc32));
        check("w8_accept_vs_deliver", 64'(done8), 64'(acc8));
        check("w32_traffic", 64'(acc32 > 20), 64'd1);
        check("w8_traffic", 64'(acc8 > 20), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
